regfile_dump: RTL and testbench
===============================

# regfile_dump

Sequential read-side master for the 32×32 register file. On a start request it walks a programmable index range through one register-file read port, captures each word, and hands it out as an (index, data) beat on a valid/ready stream toward the debug/display path. It sits between the register file's rA/A port and the CPU-state monitor, and is the register file's only non-datapath reader.

## Interface
Parameters:
- DW, 32, data width; must match the register-file word width.
- AW, 5, index width; the walk covers 2^AW registers.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a dump; sampled only in IDLE.
- first_idx  in  AW  first register index; latched on an accepted start.
- last_idx  in  AW  last register index, inclusive; latched on an accepted start.
- rf_ra  out  AW  read address to the register-file read port.
- rf_a  in  DW  combinational read data from the register file for rf_ra.
- out_valid  out  1  out_idx/out_data hold a valid beat.
- out_ready  in  1  the consumer accepts the beat.
- out_idx  out  AW  index of the current beat.
- out_data  out  DW  captured register value.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- The FSM states are IDLE, READ, HOLD, and DONE.
- IDLE: drive rf_ra = 0. When start=1, latch first/last, set cur=first, and go to READ.
- READ: drive rf_ra = cur. At the next edge, capture out_data=rf_a and out_idx=cur, set out_valid=1, and go to HOLD.
- HOLD: out_valid=1 and out_idx/out_data stay stable until out_ready=1.
  - On the accepting edge, if cur==last, go to DONE.
  - Otherwise set cur=cur+1 (mod 2^AW) and go to READ.
- DONE: assert done=1 for one cycle, then return to IDLE.
- Wrap-around: when last<first, the walk runs first…2^AW−1, then 0…last. When first==last, exactly one beat is produced. A full 2^AW walk uses last=first−1 (mod 2^AW).
- start is ignored while busy. first_idx and last_idx are don't-care outside the accepting cycle.
- Register 0 is dumped like any other index; its value is whatever the register file returns (0).
- Snapshot semantics: each word is the value present at its capture edge. A register-file write on the falling edge inside the READ cycle is included in that word. Consistency across the whole dump is not guaranteed.
- Reset values:
  - state=IDLE and cur=0.
  - rf_ra=0, out_valid=0, out_idx=0, out_data=0.
  - busy=0 and done=0.

## Timing
- Start accepted at edge 0: READ is active in cycle 1, and out_valid rises after edge 1, giving a 1-cycle start-to-first-beat latency.
- Each beat costs 2 cycles (READ + HOLD) with out_ready held high. N beats take 2N cycles, then done follows in the next cycle.
- The handshake is standard: the transfer occurs on a rising edge with out_valid & out_ready both high. Once asserted, out_valid does not drop without a transfer, except on rst.
- out_ready is ignored outside HOLD.
- rst mid-operation: at the next edge the block enters IDLE with out_valid=0 and busy=0. No done pulse is produced, and a partially delivered range is abandoned.
- rst and start in the same cycle: rst wins and start is dropped.
- rf_a is sampled only at the READ→HOLD edge. Its combinational path from rf_ra must meet one clock period.

## Structure
- Shared package: the state encoding (IDLE=0, READ=1, HOLD=2, DONE=3) and the register-file constants (DW=32, AW=5, register count 32). The register file and the monitor use the same constants.
- A single flat module, no sub-module. The index counter is a plain register inside the FSM.

## Test plan
- Dump with first=3, last=5, out_ready=1, registers preloaded so r3=0x11, r4=0x22, r5=0x33 → beats (3,0x11), (4,0x22), (5,0x33) with out_valid rising 1 cycle after start. done pulses 7 cycles after start; busy covers exactly those cycles.
- Wrap-around with first=30, last=1 → beat indices 30, 31, 0, 1; the beat for r0 carries 0x0.
- Backpressure: first=last=7, out_ready held low for 5 cycles → out_valid and out_data=r7 stay stable for all 5 cycles. Raising out_ready gives one transfer, with done the cycle after.
- Concurrent write: a write of 0xDEADBEEF to r4 on the falling edge inside r4's READ cycle → the r4 beat carries 0xDEADBEEF. A start pulse while busy is ignored, so beat count and range are unchanged.
- rst asserted during HOLD of the second beat of a 0..31 dump → the next cycle has out_valid=0, busy=0, rf_ra=0, and no done pulse. A fresh start afterwards runs a clean dump from its new first_idx.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared FSM encoding and register-file constants
package regfile_dump_pkg;
  localparam int RF_DW = 32;
  localparam int RF_AW = 5;
  localparam int RF_NREG = 1 << RF_AW;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: walks a register-file index range and streams (index, data) beats
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] first_idx,
  input  logic [AW-1:0] last_idx,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_a,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);
  logic [1:0] state, nxt;
  logic [AW-1:0] cur, lst;
  always_comb begin
    nxt = state == IDLE ? (start ? READ : IDLE) :
          state == READ ? HOLD :
          state == HOLD ? (out_ready ? (cur == lst ? DONE : READ) : HOLD) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur <= '0;
      lst <= '0;
      out_valid <= 1'b0;
      out_idx <= '0;
      out_data <= '0;
    end else begin
      state <= nxt;
      out_valid <= nxt == HOLD;
      if (state == IDLE && start) begin
        cur <= first_idx;
        lst <= last_idx;
      end
      if (state == HOLD && out_ready && cur != lst) cur <= cur + 1'b1;
      if (state == READ) begin
        out_idx <= cur;
        out_data <= rf_a;
      end
    end
  end
  assign rf_ra = state == READ ? cur : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed checks of regfile_dump against a register-file model
module tb_regfile_dump;
  logic clk = 0, rst = 1, start = 0, out_ready = 0;
  logic [4:0] first_idx = 0, last_idx = 0, rf_ra, out_idx;
  logic [31:0] rf_a, out_data;
  logic out_valid, busy, done;
  logic [31:0] rf [32];
  logic [4:0] bidx [40];
  logic [31:0] bdat [40];
  int bcyc [40];
  int total = 0, bad = 0, glitch = 0, n, dcyc;
  bit inject = 0;
  regfile_dump dut (
    .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .rf_ra(rf_ra), .rf_a(rf_a), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data), .busy(busy), .done(done)
  );
  assign rf_a = rf[rf_ra];
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    first_idx = f;
    last_idx = l;
    start = 1;
    tick;
    start = 0;
    first_idx = 5'($urandom);
    last_idx = 5'($urandom);
  endtask
  task automatic collect(input int budget, output int cnt, output int dc);
    cnt = 0;
    dc = 0;
    for (int c = 1; c <= budget; c++) begin
      check("busy_run", busy, 1);
      if (inject && rf_ra == 5'd4) begin
        @(negedge clk);
        rf[4] = 32'hDEADBEEF;
        inject = 0;
      end
      if (c == glitch) begin
        start = 1;
        first_idx = 5'd10;
        last_idx = 5'd12;
      end
      if (out_valid && out_ready && cnt < 40) begin
        bidx[cnt] = out_idx;
        bdat[cnt] = out_data;
        bcyc[cnt] = c;
        cnt++;
      end
      if (done) begin
        dc = c;
        break;
      end
      tick;
      start = 0;
    end
    start = 0;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h5A000000 | i;
    rf[0] = 32'h0;
    rf[3] = 32'h11;
    rf[4] = 32'h22;
    rf[5] = 32'h33;
    tick;
    tick;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ra", rf_ra, 0);
    check("rst_idx", out_idx, 0);
    check("rst_data", out_data, 0);
    rst = 0;
    out_ready = 1;
    do_start(3, 5);
    check("t1_ra", rf_ra, 3);
    check("t1_nvalid", out_valid, 0);
    collect(30, n, dcyc);
    check("t1_n", n, 3);
    check("t1_lat", bcyc[0], 2);
    check("t1_i0", bidx[0], 3);
    check("t1_d0", bdat[0], 32'h11);
    check("t1_i1", bidx[1], 4);
    check("t1_d1", bdat[1], 32'h22);
    check("t1_i2", bidx[2], 5);
    check("t1_d2", bdat[2], 32'h33);
    check("t1_donecyc", dcyc, 7);
    tick;
    check("t1_busy_end", busy, 0);
    check("t1_done_end", done, 0);
    check("t1_valid_end", out_valid, 0);
    rf[30] = 32'hAAAA0030;
    rf[31] = 32'hAAAA0031;
    rf[1] = 32'hAAAA0001;
    do_start(30, 1);
    collect(30, n, dcyc);
    check("wr_n", n, 4);
    check("wr_i0", bidx[0], 30);
    check("wr_d0", bdat[0], 32'hAAAA0030);
    check("wr_i1", bidx[1], 31);
    check("wr_d1", bdat[1], 32'hAAAA0031);
    check("wr_i2", bidx[2], 0);
    check("wr_d2", bdat[2], 32'h0);
    check("wr_i3", bidx[3], 1);
    check("wr_d3", bdat[3], 32'hAAAA0001);
    check("wr_donecyc", dcyc, 9);
    tick;
    out_ready = 0;
    rf[7] = 32'h77777777;
    do_start(7, 7);
    tick;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", out_valid, 1);
      check("bp_idx", out_idx, 7);
      check("bp_data", out_data, 32'h77777777);
      check("bp_done", done, 0);
      if (k < 4) tick;
    end
    out_ready = 1;
    tick;
    check("bp_done_pulse", done, 1);
    check("bp_valid_drop", out_valid, 0);
    tick;
    check("bp_done_low", done, 0);
    check("bp_busy_low", busy, 0);
    rf[4] = 32'h22;
    inject = 1;
    glitch = 3;
    do_start(3, 5);
    collect(30, n, dcyc);
    glitch = 0;
    check("cw_n", n, 3);
    check("cw_i0", bidx[0], 3);
    check("cw_i1", bidx[1], 4);
    check("cw_d1", bdat[1], 32'hDEADBEEF);
    check("cw_i2", bidx[2], 5);
    check("cw_donecyc", dcyc, 7);
    tick;
    check("cw_idle", busy, 0);
    tick;
    check("cw_idle2", busy, 0);
    do_start(0, 31);
    tick;
    tick;
    tick;
    check("rs_valid_pre", out_valid, 1);
    check("rs_idx_pre", out_idx, 1);
    rst = 1;
    tick;
    rst = 0;
    check("rs_valid", out_valid, 0);
    check("rs_busy", busy, 0);
    check("rs_ra", rf_ra, 0);
    check("rs_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check("rs_nodone", done, 0);
      check("rs_idle", busy, 0);
    end
    rst = 1;
    start = 1;
    first_idx = 5'd9;
    last_idx = 5'd9;
    tick;
    rst = 0;
    start = 0;
    check("rs_start_drop", busy, 0);
    rf[20] = 32'hC0DE0020;
    rf[21] = 32'hC0DE0021;
    do_start(20, 21);
    collect(30, n, dcyc);
    check("rs2_n", n, 2);
    check("rs2_i0", bidx[0], 20);
    check("rs2_d0", bdat[0], 32'hC0DE0020);
    check("rs2_i1", bidx[1], 21);
    check("rs2_d1", bdat[1], 32'hC0DE0021);
    check("rs2_donecyc", dcyc, 5);
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
